scan_key_mux: RTL and testbench
===============================

# scan_key_mux

Registered, parametrised key-lookup multiplexer with an automatic scan mode. It selects one of `NR_KEY` {key, data} entries, either by matching an external key (direct mode) or by stepping through all entries at a programmable rate (scan mode). In scan mode it emits the current entry's key and data plus a strobe, which makes it suitable for time-multiplexing LEDs or seven-segment digits. It sits between switch/board inputs and the board output drivers in the lab top level.

## Interface
- `NR_KEY`, 4: number of table entries; must be ≥1.
- `KEY_LEN`, 2: key width in bits.
- `DATA_LEN`, 1: data width in bits.
- `SCAN_DIV`, 4: clock cycles each entry is held in scan mode; must be ≥1.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 1: 0 = direct lookup, 1 = auto-scan.
- `sel` input KEY_LEN: lookup key; used in direct mode only.
- `default_out` input DATA_LEN: output value when no key matches in direct mode.
- `lut` input NR_KEY*(KEY_LEN+DATA_LEN): flat table. Entry i occupies bits [(i+1)*W-1 : i*W], with W = KEY_LEN+DATA_LEN. Within an entry, the key is in the upper KEY_LEN bits and the data in the lower DATA_LEN bits. Entry 0 is in the LSBs.
- `out` output DATA_LEN: selected data, registered.
- `out_key` output KEY_LEN: key of the selected entry, registered.
- `hit` output 1: the selected entry is valid, registered.
- `strobe` output 1: one-cycle pulse marking a new scan entry, registered.

## Operation
- Internal state:
  - `state` ∈ {DIRECT, SCAN}.
  - `idx`, width max(1, clog2(NR_KEY)).
  - `div_cnt`, width max(1, clog2(SCAN_DIV)).
- Reset (async, immediate): state=DIRECT, idx=0, div_cnt=0, out=0, out_key=0, hit=0, strobe=0.
- Edge with mode=0:
  - state←DIRECT; idx and div_cnt hold their values (don't-care).
  - Find the lowest-index entry whose key equals `sel`.
  - If found: out←its data, out_key←sel, hit←1.
  - If not found: out←default_out, out_key←sel, hit←0.
  - strobe←0.
- Edge with mode=1 and state=DIRECT (scan entry):
  - state←SCAN, idx←0, div_cnt←0.
  - out/out_key←entry 0; hit←1; strobe←1.
- Edge with mode=1 and state=SCAN:
  - If div_cnt==SCAN_DIV-1: div_cnt←0; idx←(idx==NR_KEY-1 ? 0 : idx+1); outputs←entry at the new idx; strobe←1.
  - Otherwise: div_cnt←div_cnt+1; outputs←entry at the current idx; strobe←0.
  - hit←1.
- Outputs always reload from the live `lut`, so table changes show up one cycle later even while an entry is being held.
- Duplicate keys in direct mode: the lowest index wins; there is no OR-merging of matches.
- Switching mode 1→0 mid-scan takes effect on the next edge. A later return to scan restarts from entry 0 with a fresh division count.
- `sel` is ignored in scan mode. `default_out` is unused in scan mode.

## Timing
- Direct mode latency: 1 cycle from `sel`/`lut` change to `out`/`hit`.
- Scan mode: each entry is presented for exactly SCAN_DIV cycles. The full sequence period is NR_KEY*SCAN_DIV cycles.
- `strobe` is high in the first cycle of every entry, including entry 0 on scan entry and on wrap.
- SCAN_DIV=1: idx advances every edge and strobe stays high continuously.
- NR_KEY=1: idx stays 0; strobe still pulses every SCAN_DIV cycles.
- Reset asserted mid-scan: outputs clear immediately, without waiting for a clock. After release, operation restarts per `mode` at the first edge.
- There is no combinational path from inputs to outputs.

## Test plan
Configuration for all scenarios: NR_KEY=4, KEY_LEN=2, DATA_LEN=2, SCAN_DIV=3, with lut = {11:2'b00, 10:2'b01, 01:2'b10, 00:2'b11}.

1. Reset: assert rst asynchronously between edges → out=0, out_key=0, hit=0, strobe=0 immediately. Outputs stay 0 while rst is held.
2. Direct mode (mode=0): sel=01 → one edge later out=2'b10, out_key=01, hit=1, strobe=0. Set sel=11 → out=2'b00 after 1 cycle.
3. Miss and duplicates (mode=0): change entry 3's key to 10 and set sel=11, default_out=2'b11 → out=2'b11, hit=0. Set sel=10 → out=2'b01 (entry 2 wins over entry 3).
4. Scan sequence: set mode=1 → out_key sequence 00,00,00,01,01,01,10,10,10,11,11,11,00…, with strobe high on cycles 1,4,7,10,13.
5. Mid-scan mode change: switch mode to 0 while out_key=10 and sel=00 → next edge out=2'b11, strobe=0. Return mode to 1 → restart at key 00 with strobe=1.
6. Reset mid-scan at idx=2: assert rst → outputs clear at once. Release rst with mode=1 → first edge presents entry 0 with strobe=1.

Source files
------------

// File: rtl/scan_key_mux.sv
// Registered key-lookup multiplexer: direct key match or timed auto-scan over all
// table entries, emitting each entry's key/data with a strobe on its first cycle.
module scan_key_mux #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mode,
    input  logic [KEY_LEN-1:0]                   sel,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic [KEY_LEN-1:0]                   out_key,
    output logic                                 hit,
    output logic                                 strobe
);
    localparam int W     = KEY_LEN + DATA_LEN;
    localparam int IDX_W = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

    typedef enum logic {DIRECT = 1'b0, SCAN = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [DIV_W-1:0]    div_reg, div_next;
    logic [DATA_LEN-1:0] out_next;
    logic [KEY_LEN-1:0]  out_key_next;
    logic                hit_next, strobe_next;

    logic [KEY_LEN-1:0]  key_arr  [NR_KEY];
    logic [DATA_LEN-1:0] data_arr [NR_KEY];
    logic                match_found;
    logic [DATA_LEN-1:0] match_data;

    // Unpack the flat table: key in the upper bits, data in the lower bits of each entry.
    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_unpack
            assign key_arr[gi]  = lut[gi*W + DATA_LEN +: KEY_LEN];
            assign data_arr[gi] = lut[gi*W +: DATA_LEN];
        end
    endgenerate

    // Walk from the top down so the lowest matching index overwrites the others.
    always_comb begin
        match_found = 1'b0;
        match_data  = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (key_arr[i] == sel) begin
                match_found = 1'b1;
                match_data  = data_arr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DIRECT;
            idx_reg   <= '0;
            div_reg   <= '0;
            out       <= '0;
            out_key   <= '0;
            hit       <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            div_reg   <= div_next;
            out       <= out_next;
            out_key   <= out_key_next;
            hit       <= hit_next;
            strobe    <= strobe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        div_next   = div_reg;
        if (!mode) begin
            state_next = DIRECT;
        end else if (state_reg == DIRECT) begin
            state_next = SCAN;
            idx_next   = '0;
            div_next   = '0;
        end else if (div_reg == LAST_DIV) begin
            div_next = '0;
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end else begin
            div_next = div_reg + 1'b1;
        end
    end

    // Scan outputs follow the entry at the upcoming index, read from the live table.
    always_comb begin
        out_next     = default_out;
        out_key_next = sel;
        hit_next     = 1'b0;
        strobe_next  = 1'b0;
        if (mode) begin
            out_next     = data_arr[idx_next];
            out_key_next = key_arr[idx_next];
            hit_next     = 1'b1;
            strobe_next  = (state_reg == DIRECT) || (div_reg == LAST_DIV);
        end else if (match_found) begin
            out_next = match_data;
            hit_next = 1'b1;
        end
    end
endmodule

// File: tb/tb_scan_key_mux.sv
// Directed bench for scan_key_mux: NR_KEY=4, KEY_LEN=2, DATA_LEN=2, SCAN_DIV=3.
module tb_scan_key_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [1:0] default_out;
    logic [15:0] lut;
    logic [1:0] out;
    logic [1:0] out_key;
    logic       hit;
    logic       strobe;

    int n_vec = 0;
    int n_err = 0;

    // Entry i: key i, data ~i (00:11, 01:10, 10:01, 11:00).
    localparam logic [15:0] LUT0 = {4'b1100, 4'b1001, 4'b0110, 4'b0011};
    // Entry 3 rekeyed to 10, duplicating entry 2.
    localparam logic [15:0] LUT1 = {4'b1000, 4'b1001, 4'b0110, 4'b0011};
    // LUT0 with entry 0's data changed to 00.
    localparam logic [15:0] LUT2 = {4'b1100, 4'b1001, 4'b0110, 4'b0000};

    scan_key_mux #(
        .NR_KEY(4), .KEY_LEN(2), .DATA_LEN(2), .SCAN_DIV(3)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .default_out(default_out),
        .lut(lut), .out(out), .out_key(out_key), .hit(hit), .strobe(strobe)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got key/out/hit/strobe=%b_%b_%b_%b expected %b_%b_%b_%b",
                     tag, obs[5:4], obs[3:2], obs[1], obs[0], exp[5:4], exp[3:2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: key/out/hit/strobe=%b_%b_%b_%b", tag, obs[5:4], obs[3:2], obs[1], obs[0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs_now();
        return {out_key, out, hit, strobe};
    endfunction

    initial begin
        logic [1:0] ek;
        rst = 1'b1; mode = 1'b0; sel = 2'b00; default_out = 2'b00; lut = LUT0;
        tick;
        check_vec("reset_held", obs_now(), 6'b00_00_0_0);
        tick;
        rst = 1'b0;

        sel = 2'b01;
        tick;
        check_vec("direct_sel01", obs_now(), 6'b01_10_1_0);
        sel = 2'b11;
        tick;
        check_vec("direct_sel11", obs_now(), 6'b11_00_1_0);

        #3 rst = 1'b1;
        #1 check_vec("async_reset", obs_now(), 6'b00_00_0_0);
        tick;
        check_vec("reset_hold_edge", obs_now(), 6'b00_00_0_0);
        rst = 1'b0;

        lut = LUT1; sel = 2'b11; default_out = 2'b11;
        tick;
        check_vec("direct_miss", obs_now(), 6'b11_11_0_0);
        sel = 2'b10;
        tick;
        check_vec("direct_dup_low_wins", obs_now(), 6'b10_01_1_0);

        lut = LUT0; mode = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick;
            ek = 2'(((k - 1) / 3) % 4);
            check_vec($sformatf("scan_c%0d", k), obs_now(), {ek, ~ek, 1'b1, 1'(k % 3 == 1)});
        end

        mode = 1'b0; sel = 2'b00;
        tick;
        check_vec("scan_to_direct", obs_now(), 6'b00_11_1_0);
        mode = 1'b1;
        tick;
        check_vec("rescan_restart", obs_now(), 6'b00_11_1_1);
        for (int k = 2; k <= 7; k++) begin
            tick;
            ek = 2'(((k - 1) / 3) % 4);
            check_vec($sformatf("rescan_c%0d", k), obs_now(), {ek, ~ek, 1'b1, 1'(k % 3 == 1)});
        end

        #3 rst = 1'b1;
        #1 check_vec("reset_mid_scan", obs_now(), 6'b00_00_0_0);
        tick;
        check_vec("reset_mid_scan_hold", obs_now(), 6'b00_00_0_0);
        rst = 1'b0;
        tick;
        check_vec("post_reset_entry0", obs_now(), 6'b00_11_1_1);
        lut = LUT2;
        tick;
        check_vec("live_lut_in_hold", obs_now(), 6'b00_00_1_0);
        lut = LUT0;
        tick;
        check_vec("hold_end", obs_now(), 6'b00_11_1_0);
        tick;
        check_vec("advance_entry1", obs_now(), 6'b01_10_1_1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
